div_seq: RTL and testbench

Multi-cycle divide sequencer for the EX stage. Accepts a DIV/DIVU request, runs a 32-iteration restoring division, holds the pipeline via a stall request, and returns {remainder, quotient} for the HI/LO write path. HI receives the remainder and LO the quotient. EX keeps driving the operands and start until ready is seen.

---
 rtl/div_seq.sv | 87 ++++++++
 tb/tb_div_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider (DIV/DIVU) with a pipeline stall request and a {remainder, quotient} result
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);
  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BYZERO = 2'd1;
  localparam logic [1:0] ON     = 2'd2;
  localparam logic [1:0] END    = 2'd3;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   p, p_sh, diff, p_n;
  logic [WIDTH-1:0] q, q_n, dvs, mag1, mag2, quo, rem;
  logic             neg_q, neg_r, s1, s2;
  assign s1   = signed_div_i & opdata1_i[WIDTH-1];
  assign s2   = signed_div_i & opdata2_i[WIDTH-1];
  assign mag1 = s1 ? -opdata1_i : opdata1_i;
  assign mag2 = s2 ? -opdata2_i : opdata2_i;
  // One restoring step: shift in the next dividend bit, keep the difference if it did not go negative.
  assign p_sh = {p[WIDTH-1:0], q[WIDTH-1]};
  assign diff = p_sh - {1'b0, dvs};
  assign p_n  = diff[WIDTH] ? p_sh : diff;
  assign q_n  = {q[WIDTH-2:0], ~diff[WIDTH]};
  assign quo  = neg_q ? -q_n : q_n;
  assign rem  = neg_r ? -p_n[WIDTH-1:0] : p_n[WIDTH-1:0];
  assign stallreq_o = !rst && (state == ON || state == BYZERO || (state == FREE && start_i && !annul_i));
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      p        <= '0;
      q        <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: if (start_i && !annul_i) begin
          state <= (opdata2_i == '0) ? BYZERO : ON;
          cnt   <= '0;
          p     <= '0;
          q     <= mag1;
          dvs   <= mag2;
          neg_q <= s1 ^ s2;
          neg_r <= s1;
        end
        BYZERO: begin
          state   <= annul_i ? FREE : END;
          ready_o <= !annul_i;
          result_o <= '0;
        end
        ON: if (annul_i) begin
          state <= FREE;
          cnt   <= '0;
        end else begin
          p   <= p_n;
          q   <= q_n;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= END;
            result_o <= {rem, quo};
            ready_o  <= 1'b1;
          end
        end
        END: if (!start_i) begin
          state    <= FREE;
          ready_o  <= 1'b0;
          result_o <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: randomized and directed checks of div_seq against a plain-arithmetic divide model
module tb_div_seq;
  logic        clk = 0, rst = 1, sgn = 0, start = 0, annul = 0;
  logic [31:0] a = 0, b = 0;
  logic [63:0] result;
  logic        ready, stallreq;
  int checks = 0, failures = 0;

  div_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(sgn), .opdata1_i(a), .opdata2_i(b),
    .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready), .stallreq_o(stallreq)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(logic [31:0] x, logic [31:0] y, logic sg);
    longint sx, sy, qq, rr;
    if (y == 0) return 64'd0;
    sx = sg ? {{32{x[31]}}, x} : {32'd0, x};
    sy = sg ? {{32{y[31]}}, y} : {32'd0, y};
    qq = sx / sy;
    rr = sx % sy;
    return {rr[31:0], qq[31:0]};
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives one request from a FREE negedge, scrambling operands while busy; lat = edges until ready (-1 on timeout).
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic sg,
                        output logic [63:0] res, output int lat, output int bad);
    a = x; b = y; sgn = sg; start = 1; annul = 0;
    lat = 0; bad = 0;
    #1 if (stallreq !== 1'b1) bad++;
    for (int i = 0; i < 100; i++) begin
      cycle();
      lat++;
      if (ready === 1'b1) break;
      if (stallreq !== 1'b1) bad++;
      a = $urandom; b = $urandom; sgn = 1'($urandom);
    end
    res = result;
    if (ready !== 1'b1) lat = -1;
    else if (stallreq !== 1'b0) bad++;
  endtask

  task automatic release_op();
    start = 0;
    cycle();
  endtask

  task automatic test_reset();
    rst = 1; start = 1; a = 10; b = 2;
    #1 checks++;
    if (stallreq !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", stallreq); end
    cycle(); cycle();
    checks++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      failures++; $display("FAIL reset_out ready=%b result=%h want 0/0", ready, result);
    end
    start = 0; rst = 0;
    cycle();
  endtask

  task automatic test_divu();
    logic [63:0] res, exp; int lat, bad; logic [31:0] x, y;
    run_op(32'd100, 32'd7, 1'b0, res, lat, bad);
    checks++;
    if (res !== {32'd2, 32'd14} || lat !== 33 || bad !== 0) begin
      failures++; $display("FAIL divu_100_7 res=%h lat=%0d badstall=%0d want=%h lat=33", res, lat, bad, {32'd2, 32'd14});
    end
    cycle();
    checks++;
    if (ready !== 1'b1 || result !== {32'd2, 32'd14}) begin
      failures++; $display("FAIL divu_hold ready=%b result=%h", ready, result);
    end
    release_op();
    checks++;
    if (ready !== 1'b0 || result !== 64'd0 || stallreq !== 1'b0) begin
      failures++; $display("FAIL divu_release ready=%b result=%h stall=%b want 0", ready, result, stallreq);
    end
    for (int i = 0; i < 6; i++) begin
      x = $urandom; y = (i % 2) ? $urandom_range(1, 50) : $urandom;
      if (y == 0) y = 1;
      exp = ref_div(x, y, 1'b0);
      run_op(x, y, 1'b0, res, lat, bad);
      checks++;
      if (res !== exp || lat !== 33 || bad !== 0) begin
        failures++; $display("FAIL divu_rand %h/%h res=%h want=%h lat=%0d bad=%0d", x, y, res, exp, lat, bad);
      end
      release_op();
    end
  endtask

  task automatic test_div_signed();
    logic [63:0] res, exp; int lat, bad; logic [31:0] x, y;
    run_op(32'hFFFFFFF9, 32'd2, 1'b1, res, lat, bad);
    checks++;
    if (res !== {32'hFFFFFFFF, 32'hFFFFFFFD} || lat !== 33 || bad !== 0) begin
      failures++; $display("FAIL div_m7_2 res=%h want=ffffffff_fffffffd lat=%0d bad=%0d", res, lat, bad);
    end
    release_op();
    run_op(32'd7, 32'hFFFFFFFE, 1'b1, res, lat, bad);
    checks++;
    if (res !== {32'd1, 32'hFFFFFFFD} || lat !== 33 || bad !== 0) begin
      failures++; $display("FAIL div_7_m2 res=%h want=00000001_fffffffd lat=%0d bad=%0d", res, lat, bad);
    end
    release_op();
    for (int i = 0; i < 8; i++) begin
      x = $urandom;
      y = (i % 2) ? $urandom : 32'($urandom_range(1, 40));
      if (i % 4 == 3) y = -y;
      if (y == 0) y = 3;
      exp = ref_div(x, y, 1'b1);
      run_op(x, y, 1'b1, res, lat, bad);
      checks++;
      if (res !== exp || lat !== 33 || bad !== 0) begin
        failures++; $display("FAIL div_rand %h/%h res=%h want=%h lat=%0d bad=%0d", x, y, res, exp, lat, bad);
      end
      release_op();
    end
  endtask

  task automatic test_byzero();
    logic [63:0] res; int lat, bad;
    run_op(32'd5, 32'd0, 1'b0, res, lat, bad);
    checks++;
    if (res !== 64'd0 || lat !== 2 || bad !== 0) begin
      failures++; $display("FAIL divu_by_zero res=%h lat=%0d bad=%0d want 0 lat=2", res, lat, bad);
    end
    release_op();
    run_op(32'hFFFFFFFB, 32'd0, 1'b1, res, lat, bad);
    checks++;
    if (res !== 64'd0 || lat !== 2 || bad !== 0) begin
      failures++; $display("FAIL div_by_zero res=%h lat=%0d bad=%0d want 0 lat=2", res, lat, bad);
    end
    release_op();
  endtask

  task automatic test_annul();
    logic [63:0] res; int lat, bad, rises;
    a = 32'hFFFFFFFF; b = 32'd1; sgn = 0; start = 1; annul = 0;
    for (int i = 0; i < 10; i++) cycle();
    checks++;
    if (ready !== 1'b0 || stallreq !== 1'b1) begin
      failures++; $display("FAIL annul_busy ready=%b stall=%b want 0/1", ready, stallreq);
    end
    annul = 1; start = 0;
    cycle();
    annul = 0;
    #1 checks++;
    if (ready !== 1'b0 || result !== 64'd0 || stallreq !== 1'b0) begin
      failures++; $display("FAIL annul_free ready=%b result=%h stall=%b want 0", ready, result, stallreq);
    end
    rises = 0;
    for (int i = 0; i < 40; i++) begin cycle(); if (ready !== 1'b0) rises++; end
    checks++;
    if (rises !== 0) begin failures++; $display("FAIL annul_no_ready got=%0d ready cycles want=0", rises); end
    start = 1; annul = 1; a = 32'd8; b = 32'd0;
    cycle();
    cycle();
    annul = 0; start = 0;
    #1 checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL annul_blocks_free ready=%b want=0", ready); end
    cycle();
    run_op(32'hFFFFFFFF, 32'd1, 1'b0, res, lat, bad);
    checks++;
    if (res !== {32'd0, 32'hFFFFFFFF} || lat !== 33 || bad !== 0) begin
      failures++; $display("FAIL annul_retry res=%h lat=%0d bad=%0d want 00000000_ffffffff", res, lat, bad);
    end
    release_op();
    a = 32'd5; b = 32'd0; start = 1;
    cycle();
    annul = 1; start = 0;
    cycle();
    annul = 0;
    cycle();
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL annul_byzero ready=%b want=0", ready); end
  endtask

  task automatic test_overflow();
    logic [63:0] res; int lat, bad;
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, res, lat, bad);
    checks++;
    if (res !== {32'd0, 32'h80000000} || lat !== 33 || bad !== 0) begin
      failures++; $display("FAIL div_overflow res=%h want=00000000_80000000 lat=%0d bad=%0d", res, lat, bad);
    end
    release_op();
  endtask

  task automatic test_rst_mid();
    logic [63:0] res; int lat, bad;
    a = 32'd1234567; b = 32'd89; sgn = 0; start = 1;
    for (int i = 0; i < 15; i++) cycle();
    rst = 1;
    #1 checks++;
    if (stallreq !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b want=0", stallreq); end
    cycle();
    checks++;
    if (ready !== 1'b0 || result !== 64'd0 || stallreq !== 1'b0) begin
      failures++; $display("FAIL rst_mid ready=%b result=%h stall=%b want 0", ready, result, stallreq);
    end
    start = 0; rst = 0;
    cycle();
    run_op(32'd9, 32'd3, 1'b0, res, lat, bad);
    checks++;
    if (res !== {32'd0, 32'd3} || lat !== 33 || bad !== 0) begin
      failures++; $display("FAIL rst_then_9_3 res=%h lat=%0d bad=%0d want 00000000_00000003", res, lat, bad);
    end
    release_op();
  endtask

  task automatic test_back_to_back();
    logic [63:0] res, exp; int lat, bad; logic [31:0] x, y; logic sg;
    for (int i = 0; i < 4; i++) begin
      x = $urandom; y = $urandom_range(0, 3) == 0 ? 32'd0 : 32'($urandom_range(1, 1000)); sg = 1'(i);
      exp = ref_div(x, y, sg);
      run_op(x, y, sg, res, lat, bad);
      checks++;
      if (res !== exp || lat !== (y == 0 ? 2 : 33) || bad !== 0) begin
        failures++; $display("FAIL b2b %h/%h s=%b res=%h want=%h lat=%0d bad=%0d", x, y, sg, res, exp, lat, bad);
      end
      release_op();
      checks++;
      if (ready !== 1'b0 || result !== 64'd0) begin
        failures++; $display("FAIL b2b_gap ready=%b result=%h want 0", ready, result);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_divu();
    test_div_signed();
    test_byzero();
    test_annul();
    test_overflow();
    test_rst_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
